// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte handshake bundle for uart_rx
interface uart_rx_if;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready;

   modport master (
      output data_out,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_out,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, framing/overrun flags
module uart_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx,
   input  logic [13:0]       baud_tick_max,
   uart_rx_if.master         rx_bus,
   output logic              busy,
   output logic              framing_error,
   output logic              overrun
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;
   logic [13:0]            n_q, n_d;
   logic [13:0]            cnt_q, cnt_d;
   logic [2:0]             bit_idx_q, bit_idx_d;
   logic [7:0]             shift_q, shift_d;
   logic [13:0]            half_m1;
   logic [13:0]            full_m1;
   logic                   byte_done;
   logic                   frame_err;

   // Idle-high line, so the synchronizer resets to 1 to avoid a false start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      end
   end

   assign rx_s    = sync_q[SYNC_STAGES-1];
   assign half_m1 = (n_q >> 1) - 14'd1;
   assign full_m1 = n_q - 14'd1;
   assign busy    = (state_q != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         n_q       <= '0;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      byte_done = 1'b0;
      frame_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = '0;
               // Bit period is frozen for the whole frame; tiny values clamp to 4.
               n_d     = (baud_tick_max < 14'd4) ? 14'd4 : baud_tick_max;
            end
         end
         START: begin
            if (cnt_q == half_m1) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d   = DATA;
                  bit_idx_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 14'd1;
            end
         end
         DATA: begin
            if (cnt_q == full_m1) begin
               shift_d[bit_idx_q] = rx_s;
               cnt_d              = '0;
               bit_idx_d          = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               cnt_d = cnt_q + 14'd1;
            end
         end
         STOP: begin
            if (cnt_q == full_m1) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d   = IDLE;
                  byte_done = 1'b1;
               end else begin
                  state_d   = BREAK;
                  frame_err = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 14'd1;
            end
         end
         BREAK: begin
            // A held-low line must return high before another start is accepted.
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_bus.data_out   <= '0;
         rx_bus.data_valid <= 1'b0;
         framing_error     <= 1'b0;
         overrun           <= 1'b0;
      end else begin
         framing_error <= frame_err;
         overrun       <= 1'b0;
         if (byte_done) begin
            if (!rx_bus.data_valid || rx_bus.data_ready) begin
               rx_bus.data_out   <= shift_q;
               rx_bus.data_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_bus.data_valid && rx_bus.data_ready) begin
            rx_bus.data_valid <= 1'b0;
         end
      end
   end

endmodule
